// File: rtl/bt_uart_pkg.sv
// ---------------------------------------------------------------------------
// bt_uart_pkg
// Definitions shared by the Bluetooth UART command receiver and the status
// transmitter: transmitter state encoding, command byte values and status
// byte values.
// Build option: UART_TX_PARITY_EN (used by bt_status_tx) selects 8E1 framing.
// ---------------------------------------------------------------------------
package bt_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } bt_tx_state_e;

  // Command bytes sent by the phone app
  localparam logic [7:0] CMD_VOL_DEC = 8'hB0;
  localparam logic [7:0] CMD_VOL_INC = 8'hB1;
  localparam logic [7:0] CMD_NEXT    = 8'hB2;
  localparam logic [7:0] CMD_PREV    = 8'hB3;
  localparam logic [7:0] CMD_RESET   = 8'hB4;

  // Status bytes returned by the player
  localparam logic [7:0] STAT_ACK    = 8'hC0;
  localparam logic [7:0] STAT_NAK    = 8'hC1;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [7:0] i_byte);
    return ^i_byte;
  endfunction

endpackage

// File: rtl/bt_tx_fifo.sv
// ---------------------------------------------------------------------------
// bt_tx_fifo
// Small synchronous byte FIFO between player logic and the UART framer.
// Pointers wrap naturally; a separate count distinguishes full from empty.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   write request and byte (ignored while full)
//   i_pop            read request (ignored while empty)
//   o_data           head byte (valid while !o_empty)
//   o_full, o_empty  occupancy flags from the registered count
//   o_count          number of stored bytes
// ---------------------------------------------------------------------------
module bt_tx_fifo
  import bt_uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_push,
  input  logic [7:0]                    i_data,
  input  logic                          i_pop,
  output logic [7:0]                    o_data,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bt_status_tx.sv
// ---------------------------------------------------------------------------
// bt_status_tx
// UART transmitter returning status/acknowledge bytes to the phone app.
// Bytes are buffered in bt_tx_fifo and sent as 8N1 frames, LSB first, or as
// 8E1 frames when UART_TX_PARITY_EN is defined at build time.
// Ports:
//   uart_clk   sole clock
//   rst_n      asynchronous active-low reset (truncates any frame in flight)
//   tx_data    byte to send
//   tx_valid   tx_data valid; hold until tx_ready
//   tx_ready   FIFO has a free slot
//   tx_busy    frame on the line or bytes waiting
//   data_out   registered serial line, idle high
//
// state  | meaning
// IDLE   | line high, waiting for a byte in the FIFO
// START  | start bit (low)
// DATA   | data bits 0..7, LSB first
// PARITY | even parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit (high); chains straight into START if bytes wait
// ---------------------------------------------------------------------------
module bt_status_tx
  import bt_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       uart_clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       data_out
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BAUD_W       = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] S_IDLE   = 3'(ST_IDLE);
  localparam logic [2:0] S_START  = 3'(ST_START);
  localparam logic [2:0] S_DATA   = 3'(ST_DATA);
  localparam logic [2:0] S_PARITY = 3'(ST_PARITY);
  localparam logic [2:0] S_STOP   = 3'(ST_STOP);

  logic [2:0]                  r_state;
  logic [BAUD_W-1:0]           r_baud;
  logic [2:0]                  r_bit_idx;
  logic [7:0]                  r_frame_byte;
  logic                        r_data_out;

  logic [2:0]                  w_state_nxt;
  logic [BAUD_W-1:0]           w_baud_nxt;
  logic [2:0]                  w_bit_nxt;
  logic                        w_out_nxt;
  logic                        w_pop;
  logic                        w_baud_done;
  logic [7:0]                  w_fifo_data;
  logic                        w_full;
  logic                        w_empty;
  logic [$clog2(FIFO_DEPTH):0] w_count;

  bt_tx_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (uart_clk),
    .i_rst_n (rst_n),
    .i_push  (tx_valid),
    .i_data  (tx_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_baud_done = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx_ready    = !w_full;
  assign tx_busy     = (r_state != S_IDLE) || !w_empty;
  assign data_out    = r_data_out;

  // The next line level is decided together with the next state so that
  // data_out changes on the same edge as the state it belongs to.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_bit_nxt   = r_bit_idx;
    w_out_nxt   = r_data_out;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_out_nxt  = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
          w_out_nxt   = 1'b0;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
          w_out_nxt   = r_frame_byte[0];
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = S_PARITY;
            w_out_nxt   = even_parity(r_frame_byte);
`else
            w_state_nxt = S_STOP;
            w_out_nxt   = 1'b1;
`endif
          end else begin
            w_bit_nxt = r_bit_idx + 3'd1;
            w_out_nxt = r_frame_byte[r_bit_idx + 3'd1];
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_baud_done) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
          w_out_nxt   = 1'b1;
        end else begin
          w_baud_nxt  = r_baud + 1'b1;
        end
      end
      S_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = '0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
            w_out_nxt   = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_out_nxt   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_baud       <= '0;
      r_bit_idx    <= 3'd0;
      r_frame_byte <= 8'h00;
      r_data_out   <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_data_out <= w_out_nxt;
      if (w_pop) r_frame_byte <= w_fifo_data;
    end
  end

endmodule

// File: tb/tb_bt_status_tx.sv
module tb_bt_status_tx;
  import bt_uart_pkg::*;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FL = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        tx_ready;
  wire        tx_busy;
  wire        data_out;

  always #5 clk = ~clk;

  bt_status_tx #(
    .CLK_FREQ   (1_000_000),
    .BAUD_RATE  (100_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .uart_clk (clk),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_busy  (tx_busy),
    .data_out (data_out)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: a byte queue plus the position inside the current frame
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_t = 0;
  logic [7:0] m_cur = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (PAR && idx == 9) return ^b;
    return 1'b1;
  endfunction

  initial begin
    bit acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        m_active = 1'b0;
        m_t      = 0;
      end else begin
        acc = tx_valid && (mq.size() < DEPTH);
        if (m_active) begin
          if (m_t == FL - 1) begin
            if (mq.size() > 0) begin
              m_cur = mq.pop_front();
              m_t   = 0;
            end else begin
              m_active = 1'b0;
            end
          end else begin
            m_t++;
          end
        end else if (mq.size() > 0) begin
          m_cur    = mq.pop_front();
          m_active = 1'b1;
          m_t      = 0;
        end
        if (acc) mq.push_back(tx_data);
      end
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    check("line",  data_out, m_active ? frame_bit(m_cur, m_t / CPB) : 1'b1);
    check("ready", tx_ready, (mq.size() < DEPTH));
    check("busy",  tx_busy,  (m_active || mq.size() > 0));
  end

  task automatic push(input logic [7:0] d, output int acc_cyc);
    int n;
    n = 0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = d;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", tx_ready, 1'b1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
  endtask

  task automatic release_valid();
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (tx_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", tx_busy, 1'b0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int a0, ac;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("idle_line",  data_out, 1'b1);
    check("idle_ready", tx_ready, 1'b1);
    check("idle_busy",  tx_busy,  1'b0);

    // Single ACK frame, pinned with literal bit values
    push(STAT_ACK, a0);
    release_valid();
    wait_cyc(a0 + 1);   check("c0_start_first", data_out, 1'b0);
    wait_cyc(a0 + 10);  check("c0_start_last",  data_out, 1'b0);
    wait_cyc(a0 + 11);  check("c0_bit0",        data_out, 1'b0);
    wait_cyc(a0 + 61);  check("c0_bit5",        data_out, 1'b0);
    wait_cyc(a0 + 71);  check("c0_bit6",        data_out, 1'b1);
    wait_cyc(a0 + 81);  check("c0_bit7",        data_out, 1'b1);
    wait_cyc(a0 + 91);  check("c0_after_bit7",  data_out, PAR ? 1'b0 : 1'b1);
    wait_cyc(a0 + FL);  check("c0_busy_last",   tx_busy,  1'b1);
    wait_cyc(a0 + FL + 1);
    check("c0_busy_done", tx_busy,  1'b0);
    check("c0_line_done", data_out, 1'b1);
    drain();

    // Burst of five bytes, then a held byte while full
    push(8'hA5, a0);
    push(8'h3C, ac);
    push(8'hFF, ac);
    push(8'h01, ac);
    push(8'h5A, ac);
    check("burst_full", tx_ready, 1'b0);
    push(8'h77, ac);
    check("held_accept_cycle", ac, a0 + FL + 2);
    release_valid();
    drain();

    // Reset in the middle of a frame
    push(8'h3C, a0);
    release_valid();
    wait_cyc(a0 + 35);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_line",  data_out, 1'b1);
    check("rst_busy",  tx_busy,  1'b0);
    check("rst_ready", tx_ready, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_fifo_empty", dut.u_fifo.o_count, 0);
    push(8'h5A, a0);
    release_valid();
    wait_cyc(a0 + 1);
    check("post_rst_start", data_out, 1'b0);
    drain();

    // Push on the same edge the FSM pops with two bytes waiting
    push(8'h11, a0);
    push(8'h22, ac);
    push(8'h33, ac);
    release_valid();
    wait_cyc(a0 + FL - 1);
    push(8'h44, ac);
    check("pp_accept_cycle", ac, a0 + FL + 1);
    check("pp_count", dut.u_fifo.o_count, 2);
    release_valid();
    drain();

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      tx_valid = ($urandom_range(0, 7) == 0);
      tx_data  = 8'($urandom);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
